// File: rtl/imm_gen_pipe.sv
// RV immediate decoder with a two-entry (output + skid) elastic buffer.
// Latency 1 cycle; o_ready is registered (skid empty), so backpressure never loops combinationally.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [31:0]     o_instr,
    output logic            o_unsup
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [31:0]     instr;
        logic            unsup;
    } entry_t;

    entry_t      dec;
    logic [31:0] imm32;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_vld_q, out_vld_d;
    logic   skid_vld_q, skid_vld_d;

    logic   accept;
    logic   drain;

    always_comb begin
        imm32     = '0;
        dec       = '0;
        dec.instr = i_instr;
        case (i_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                end else begin
                    dec.unsup = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {i_instr[31:12], 12'h000};
            end
            7'b1110011: begin
                if (EN_ZICSR) begin
                    dec.fmt = FMT_Z;
                    imm32   = {27'd0, i_instr[19:15]};
                end else begin
                    dec.unsup = 1'b1;
                end
            end
            default: begin
                dec.fmt   = FMT_NONE;
                dec.unsup = 1'b1;
            end
        endcase
        // Bit 31 is the sign for every format; zimm always has it clear.
        dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    end

    assign accept = i_valid & o_ready;
    assign drain  = out_vld_q & i_ready;

    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || drain) begin
            // OUT is free this cycle: the skid entry is older than any new accept.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_ready = ~skid_vld_q;
    assign o_valid = out_vld_q;
    assign o_imm   = out_q.imm;
    assign o_fmt   = out_q.fmt;
    assign o_instr = out_q.instr;
    assign o_unsup = out_q.unsup;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit/Zicsr instance and a 64-bit/no-Zicsr instance share stimulus.
module tb_imm_gen_pipe;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_valid, i_ready;
    logic [31:0] i_instr;

    logic        rdy32, vld32, uns32;
    logic [31:0] imm32, ins32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, uns64;
    logic [63:0] imm64;
    logic [31:0] ins64;
    logic [2:0]  fmt64;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b1)) u_dut32 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(rdy32), .i_instr(i_instr),
        .o_valid(vld32), .i_ready(i_ready), .o_imm(imm32),
        .o_fmt(fmt32), .o_instr(ins32), .o_unsup(uns32)
    );

    imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b0)) u_dut64 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(rdy64), .i_instr(i_instr),
        .o_valid(vld64), .i_ready(i_ready), .o_imm(imm64),
        .o_fmt(fmt64), .o_instr(ins64), .o_unsup(uns64)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        uns32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        uns64;
    } vec_t;

    vec_t vecs[$];

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_instr = 32'h0;

        // Reset state
        step(); step();
        chk("rst_vld", vld32, 0);
        chk("rst_rdy", rdy32, 1);
        chk("rst_imm", imm32, 0);
        chk("rst_fmt", fmt32, 0);
        chk("rst_ins", ins32, 0);
        chk("rst_uns", uns32, 0);
        i_reset = 1'b0;
        step();

        // Decode vectors: instr, imm/fmt/unsup for XLEN32+Zicsr, then XLEN64 without Zicsr
        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0});
        vecs.push_back('{32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h0, 3'd0, 1'b1});
        vecs.push_back('{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0});
        vecs.push_back('{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1});
        vecs.push_back('{32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0});
        vecs.push_back('{32'hFE112C23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0});
        vecs.push_back('{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h800, 3'd5, 1'b0});
        vecs.push_back('{32'hFFFFF0EF, 32'hFFFFFFFE, 3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 3'd5, 1'b0});
        vecs.push_back('{32'h12345017, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0});
        vecs.push_back('{32'hFFF5B083, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0});

        foreach (vecs[k]) begin
            i_valid = 1'b1; i_instr = vecs[k].instr;
            step();
            i_valid = 1'b0;
            chk($sformatf("v%0d_vld", k), vld32, 1);
            chk($sformatf("v%0d_imm32", k), imm32, vecs[k].imm32);
            chk($sformatf("v%0d_fmt32", k), fmt32, vecs[k].fmt32);
            chk($sformatf("v%0d_uns32", k), uns32, vecs[k].uns32);
            chk($sformatf("v%0d_ins32", k), ins32, vecs[k].instr);
            chk($sformatf("v%0d_imm64", k), imm64, vecs[k].imm64);
            chk($sformatf("v%0d_fmt64", k), fmt64, vecs[k].fmt64);
            chk($sformatf("v%0d_uns64", k), uns64, vecs[k].uns64);
        end
        step();
        chk("idle_vld", vld32, 0);

        // Stall: A to OUT, B to SKID, C held upstream
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00500093;
        step();
        chk("stall_a_out", ins32, 32'h00500093);
        chk("stall_rdy1", rdy32, 1);
        i_instr = 32'h00600093;
        step();
        chk("stall_rdy0", rdy32, 0);
        chk("stall_hold_a", ins32, 32'h00500093);
        i_instr = 32'h00700093;
        step();
        chk("stall_still_a", ins32, 32'h00500093);
        chk("stall_still_rdy0", rdy32, 0);
        chk("stall_vld", vld32, 1);
        i_ready = 1'b1;
        step();
        chk("order_b", ins32, 32'h00600093);
        chk("order_b_vld", vld32, 1);
        chk("order_rdy", rdy32, 1);
        step();
        i_valid = 1'b0;
        chk("order_c", ins32, 32'h00700093);
        chk("order_c_imm", imm32, 32'h7);
        chk("order_c_vld", vld32, 1);
        step();
        chk("order_empty", vld32, 0);

        // Flush with both entries full; same-cycle accept is ignored
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00100093;
        step();
        i_instr = 32'h00200093;
        step();
        i_flush = 1'b1; i_instr = 32'h00300093;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_vld", vld32, 0);
        chk("flush_rdy", rdy32, 1);
        step();
        chk("flush_no_c", vld32, 0);
        i_ready = 1'b1; i_valid = 1'b1; i_instr = 32'h00400093;
        step();
        i_valid = 1'b0;
        chk("post_flush_vld", vld32, 1);
        chk("post_flush_ins", ins32, 32'h00400093);

        // Flush coinciding with a drain presents nothing further
        i_valid = 1'b1; i_instr = 32'h00800093; i_ready = 1'b0;
        step();
        i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("flush_drain_vld", vld32, 0);

        // Reset mid-stall with both entries full
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'hFFF00093;
        step();
        i_instr = 32'h0000007F;
        step();
        chk("pre_rst_rdy", rdy32, 0);
        i_reset = 1'b1; i_instr = 32'h00900093;
        step();
        i_reset = 1'b0; i_valid = 1'b0;
        chk("mrst_vld", vld32, 0);
        chk("mrst_rdy", rdy32, 1);
        chk("mrst_imm", imm32, 0);
        chk("mrst_fmt", fmt32, 0);
        chk("mrst_ins", ins32, 0);
        chk("mrst_uns", uns32, 0);
        chk("mrst_imm64", imm64, 0);
        chk("mrst_vld64", vld64, 0);
        i_ready = 1'b1;
        step();
        chk("mrst_stays_empty", vld32, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate datapath width; legal values 32 and 64.
REQ-002 Parameter EN_ZICSR, default 1; 1 decodes CSR-immediate (zimm) format, 0 treats opcode 1110011 as unsupported.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_flush  input  1  discards all buffered entries.
REQ-006 i_valid  input  1  upstream instruction valid.
REQ-007 o_ready  output  1  block can accept an instruction this cycle.
REQ-008 i_instr  input  32  instruction word.
REQ-009 o_valid  output  1  output entry valid.
REQ-010 i_ready  input  1  downstream accepts the output entry.
REQ-011 o_imm  output  XLEN  decoded immediate.
REQ-012 o_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-013 o_instr  output  32  instruction word passed through with its immediate.
REQ-014 o_unsup  output  1  opcode not decoded.

Function
REQ-015 Accept = i_valid & o_ready; drain = o_valid & i_ready.
REQ-016 Decode by i_instr[6:0]:
- I: 0010011, 0000011, 1100111, and 0011011 only when XLEN=64.
- S: 0100011.
- B: 1100011.
- J: 1101111.
- U: 0110111, 0010111.
- Z: 1110011.
REQ-017 Formats I/S/B/J use the standard RV field scatter, with B and J bit0 = 0; the result is sign-extended from instr[31] to XLEN.
REQ-018 U = {instr[31:12], 12'h0}, sign-extended from bit31 to XLEN.
REQ-019 Z = zero-extended instr[19:15] (zimm), fmt 6; decoded for every funct3 of 1110011.
REQ-020 Any other opcode (including 0011011 when XLEN=32, and 1110011 when EN_ZICSR=0): o_imm = 0, o_fmt = 0, o_unsup = 1.
REQ-021 Decode is performed combinationally on i_instr and registered on accept; output latency is exactly 1 cycle when not stalled.
REQ-022 Storage is two entries: an output register (OUT) and a skid register (SKID), each holding imm, fmt, instr and unsup plus a valid bit.
REQ-023 o_valid = OUT.valid.
REQ-024 o_ready = ~SKID.valid; o_ready never depends combinationally on i_ready.
REQ-025 Buffer transitions per cycle, with flush and reset taking priority:
- OUT empty, accept: load OUT.
- OUT full, drain, SKID empty, accept: load OUT with the new entry.
- OUT full, drain, SKID full: SKID moves to OUT and SKID clears (no accept, since o_ready = 0).
- OUT full, no drain, accept: load SKID.
- OUT full, drain, no accept, SKID empty: OUT clears.
REQ-026 Ordering is strict FIFO; no entry is dropped or duplicated, and OUT contents hold stable while o_valid & ~i_ready.
REQ-027 i_flush clears both valid bits next cycle and ignores a same-cycle accept; o_ready = 1 the following cycle.
REQ-028 Simultaneous i_flush and drain: the drained entry is counted as transferred; nothing further is presented.

Reset
REQ-029 While i_reset is high at a clock edge, OUT.valid = SKID.valid = 0, o_imm = 0, o_fmt = 0, o_instr = 0, o_unsup = 0.
REQ-030 After reset, o_valid = 0 and o_ready = 1; reset overrides flush and a same-cycle accept.
REQ-031 Reset asserted mid-stall discards both entries with no output transfer.

Verification
REQ-032 XLEN=32, i_ready=1, send 0xFFF00093 (addi -1) -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_fmt=1.
REQ-033 Send 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC, fmt=3; send 0x3002D073 (csrrwi zimm=5) -> o_imm=0x00000005, fmt=6.
REQ-034 XLEN=64: send 0x800000B7 (lui) -> o_imm=0xFFFFFFFF80000000, fmt=4; send 0x0000007F -> o_imm=0, fmt=0, o_unsup=1.
REQ-035 i_ready=0, i_valid=1 with A, B, C on consecutive cycles -> A in OUT, B in SKID, o_ready=0 and C held upstream; raise i_ready -> A, B, C delivered in order with no gaps after C is accepted.
REQ-036 With OUT and SKID full, assert i_flush for 1 cycle -> next cycle o_valid=0, o_ready=1; the next accepted instruction appears after 1 cycle.
REQ-037 Assert i_reset for 1 cycle with both entries full -> all outputs 0, o_ready=1, o_valid=0.
